// File: rtl/manchester_tx_scheduler_if.sv
// Requester handshake and serial-output bundle for manchester_tx_scheduler.
// The master modport is the requester/observer side; the slave modport is the scheduler.
interface manchester_tx_scheduler_if;
  logic        req0_valid;
  logic        req1_valid;
  logic [31:0] req0_data;
  logic [31:0] req1_data;
  logic        req0_ready;
  logic        req1_ready;
  logic        tx_bit;
  logic        tx_active;
  logic        tx_grant;
  logic        tx_done;

  modport master (
    output req0_valid, req1_valid, req0_data, req1_data,
    input  req0_ready, req1_ready, tx_bit, tx_active, tx_grant, tx_done
  );

  modport slave (
    input  req0_valid, req1_valid, req0_data, req1_data,
    output req0_ready, req1_ready, tx_bit, tx_active, tx_grant, tx_done
  );
endinterface

// File: rtl/manchester_tx_scheduler.sv
// Two-requester round-robin frame scheduler: preamble + 32-bit LSB-first payload on an NRZ tx_bit.
// Define MTX_PARITY_EN to append one even-parity bit after the payload.
module manchester_tx_scheduler #(
  parameter logic [7:0]  PREAMBLE = 8'hD5,
  parameter int unsigned IDLE_GAP = 4
) (
  input  logic                            clk108,
  input  logic                            aresetn,
  manchester_tx_scheduler_if.slave        bus
);

`ifdef MTX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_PREAMBLE, ST_PAYLOAD, ST_PARITY, ST_GAP} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_PREAMBLE, ST_PAYLOAD, ST_GAP} state_t;
`endif

  localparam logic [5:0] GAP_LAST = (IDLE_GAP == 0) ? 6'd0 : 6'(IDLE_GAP - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] shreg_q, shreg_d;
  logic        tx_bit_q, tx_bit_d;
  logic        tx_active_q, tx_active_d;
  logic        tx_done_q, tx_done_d;
  logic        tx_grant_q, tx_grant_d;
  logic        last_grant_q, last_grant_d;
`ifdef MTX_PARITY_EN
  logic        parity_q, parity_d;
`endif
  logic        sel;
  logic        rdy0, rdy1;

  // Tie goes to the requester that did not win last; otherwise whoever is valid.
  assign sel = (bus.req0_valid & bus.req1_valid) ? ~last_grant_q : bus.req1_valid;

  // NOTE: every signal driven here gets a default before the case, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 6'd1;
    shreg_d      = shreg_q;
    tx_bit_d     = 1'b0;
    tx_active_d  = 1'b0;
    tx_done_d    = 1'b0;
    tx_grant_d   = tx_grant_q;
    last_grant_d = last_grant_q;
`ifdef MTX_PARITY_EN
    parity_d     = parity_q;
`endif
    rdy0         = 1'b0;
    rdy1         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = 6'd0;
        rdy0  = bus.req0_valid & ~sel;
        rdy1  = bus.req1_valid & sel;
        if (bus.req0_valid | bus.req1_valid) begin
          state_d      = ST_PREAMBLE;
          shreg_d      = sel ? bus.req1_data : bus.req0_data;
          tx_grant_d   = sel;
          last_grant_d = sel;
          tx_bit_d     = PREAMBLE[7];
          tx_active_d  = 1'b1;
`ifdef MTX_PARITY_EN
          parity_d     = sel ? ^bus.req1_data : ^bus.req0_data;
`endif
        end
      end

      ST_PREAMBLE: begin
        tx_active_d = 1'b1;
        if (cnt_q == 6'd7) begin
          state_d  = ST_PAYLOAD;
          cnt_d    = 6'd0;
          tx_bit_d = shreg_q[0];
          shreg_d  = shreg_q >> 1;
        end else begin
          tx_bit_d = PREAMBLE[3'd6 - cnt_q[2:0]];
        end
      end

      ST_PAYLOAD: begin
        if (cnt_q == 6'd31) begin
          cnt_d = 6'd0;
`ifdef MTX_PARITY_EN
          state_d     = ST_PARITY;
          tx_bit_d    = parity_q;
          tx_active_d = 1'b1;
          tx_done_d   = 1'b1;
`else
          state_d = (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;
`endif
        end else begin
          tx_bit_d    = shreg_q[0];
          shreg_d     = shreg_q >> 1;
          tx_active_d = 1'b1;
`ifndef MTX_PARITY_EN
          tx_done_d   = (cnt_q == 6'd30);
`endif
        end
      end

`ifdef MTX_PARITY_EN
      ST_PARITY: begin
        cnt_d   = 6'd0;
        state_d = (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;
      end
`endif

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = 6'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the payload shift register is reset too, so a word aborted mid-frame never leaks out.
  always_ff @(posedge clk108) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 6'd0;
      shreg_q      <= 32'd0;
      tx_bit_q     <= 1'b0;
      tx_active_q  <= 1'b0;
      tx_done_q    <= 1'b0;
      tx_grant_q   <= 1'b0;
      last_grant_q <= 1'b1;
`ifdef MTX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      tx_bit_q     <= tx_bit_d;
      tx_active_q  <= tx_active_d;
      tx_done_q    <= tx_done_d;
      tx_grant_q   <= tx_grant_d;
      last_grant_q <= last_grant_d;
`ifdef MTX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  // Ready is held off while reset is asserted so no word is accepted then dropped.
  assign bus.req0_ready = rdy0 & aresetn;
  assign bus.req1_ready = rdy1 & aresetn;
  assign bus.tx_bit     = tx_bit_q;
  assign bus.tx_active  = tx_active_q;
  assign bus.tx_done    = tx_done_q;
  assign bus.tx_grant   = tx_grant_q;

endmodule

// File: tb/tb_manchester_tx_scheduler.sv
// Scoreboard bench for manchester_tx_scheduler: a frame-level model queues the expected
// per-cycle serial outputs at each handshake, and a negedge monitor pops and compares them.
module tb_manchester_tx_scheduler;
  localparam logic [7:0] PRE = 8'hD5;
  localparam int         GAP = 4;
`ifdef MTX_PARITY_EN
  localparam bit         PAR = 1'b1;
`else
  localparam bit         PAR = 1'b0;
`endif

  typedef struct packed {
    logic b;
    logic act;
    logic done;
    logic gnt;
  } obs_t;

  logic clk108 = 1'b0;
  logic aresetn;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   chk_en = 1'b0;
  bit   hs0, hs1;
  bit   cur_grant  = 1'b0;
  bit   last_grant = 1'b1;
  obs_t exp_q[$];

  manchester_tx_scheduler_if bus ();

  manchester_tx_scheduler #(.PREAMBLE(PRE), .IDLE_GAP(GAP)) dut (
    .clk108  (clk108),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 clk108 = ~clk108;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  // Expected frame: preamble MSB first, payload LSB first, optional even parity, then the gap.
  task automatic push_frame(input logic [31:0] w, input bit g);
    for (int i = 0; i < 8; i++) exp_q.push_back(obs_t'{PRE[7-i], 1'b1, 1'b0, g});
    for (int i = 0; i < 32; i++) exp_q.push_back(obs_t'{w[i], 1'b1, (i == 31) && !PAR, g});
    if (PAR) exp_q.push_back(obs_t'{^w, 1'b1, 1'b1, g});
    for (int i = 0; i < GAP; i++) exp_q.push_back(obs_t'{1'b0, 1'b0, 1'b0, g});
  endtask

  // Monitor and model: compare this cycle's outputs, then decide this cycle's handshake.
  always @(negedge clk108) begin
    obs_t        e;
    bit          idle;
    bit          s;
    logic [1:0]  exp_rdy;
    cyc++;
    hs0 = bus.req0_valid & bus.req0_ready;
    hs1 = bus.req1_valid & bus.req1_ready;
    if (chk_en) begin
      idle = (exp_q.size() == 0);
      e    = idle ? obs_t'{1'b0, 1'b0, 1'b0, cur_grant} : exp_q.pop_front();
      check("tx_out", {28'd0, bus.tx_bit, bus.tx_active, bus.tx_done, bus.tx_grant}, {28'd0, e});
      exp_rdy = 2'b00;
      if (!aresetn) begin
        exp_q.delete();
        cur_grant  = 1'b0;
        last_grant = 1'b1;
      end else if (idle && (bus.req0_valid || bus.req1_valid)) begin
        s = (bus.req0_valid && bus.req1_valid) ? !last_grant : bus.req1_valid;
        exp_rdy[s] = 1'b1;
        push_frame(s ? bus.req1_data : bus.req0_data, s);
        last_grant = s;
        cur_grant  = s;
      end
      check("ready", {30'd0, bus.req1_ready, bus.req0_ready}, {30'd0, exp_rdy});
    end
  end

  task automatic tick();
    @(posedge clk108);
    #1;
  endtask

  initial begin
    bit seen;
    aresetn        = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data  = 32'd0;
    bus.req1_data  = 32'd0;
    repeat (3) tick();
    chk_en = 1'b1;
    tick();
    aresetn = 1'b1;

    // Single word from requester 0.
    bus.req0_valid = 1'b1;
    bus.req0_data  = 32'hAA550FF0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = hs0;
    end
    check("req0_accept", {31'd0, seen}, 32'd1);
    bus.req0_valid = 1'b0;
    repeat (60) tick();

    // Both requesters continuously valid: strict alternation.
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_data  = 32'h11111111;
    bus.req1_data  = 32'h22222222;
    repeat (200) tick();

    // Random traffic with occasional drops before handshake and random one-cycle resets.
    for (int i = 0; i < 3000; i++) begin
      aresetn = ($urandom_range(0, 299) != 0);
      if (bus.req0_valid && !hs0) begin
        if ($urandom_range(0, 19) == 0) bus.req0_valid = 1'b0;
      end else begin
        bus.req0_valid = ($urandom_range(0, 2) == 0);
        bus.req0_data  = $urandom;
      end
      if (bus.req1_valid && !hs1) begin
        if ($urandom_range(0, 19) == 0) bus.req1_valid = 1'b0;
      end else begin
        bus.req1_valid = ($urandom_range(0, 2) == 0);
        bus.req1_data  = $urandom;
      end
      tick();
    end

    // Drain: no more requests, every queued expectation must have been consumed.
    aresetn        = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (80) tick();
    check("drain", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
